// File: rtl/mul_arbiter_if.sv
// Requester/consumer bus for mul_arbiter: per-requester operand handshakes
// on one side, a single tagged result stream on the other.
interface mul_arbiter_if #(
  parameter int TOTAL_BITS = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_BITS    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*TOTAL_BITS-1:0] req_a;
  logic [NUM_REQ*TOTAL_BITS-1:0] req_b;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [TOTAL_BITS-1:0]         rsp_data;
  logic [ID_BITS-1:0]            rsp_id;
  logic                          rsp_ovf;
  logic                          busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf, busy
  );
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf, busy
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one fixed-point multiplier across NUM_REQ requesters,
// two-stage pipeline with backpressure. Define MUL_ARB_SATURATE_EN to saturate on overflow.
module mul #(
  parameter int TOTAL_BITS      = 16,
  parameter int FRACTIONAL_BITS = 12
) (
  input  logic [TOTAL_BITS-1:0] a,
  input  logic [TOTAL_BITS-1:0] b,
  output logic [TOTAL_BITS-1:0] p
);
  assign p = TOTAL_BITS'(({{TOTAL_BITS{1'b0}}, a} * {{TOTAL_BITS{1'b0}}, b}) >> FRACTIONAL_BITS);
endmodule

module mul_arbiter #(
  parameter int TOTAL_BITS      = 16,
  parameter int FRACTIONAL_BITS = 12,
  parameter int NUM_REQ         = 4,
  parameter int ID_BITS         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic         clk,
  input  logic         reset_n,
  mul_arbiter_if.slave bus
);
  localparam int SW = ID_BITS + 1;

  logic                  adv1, adv2, gnt;
  logic [ID_BITS-1:0]    rr_ptr, gnt_idx, op_id, rsp_id;
  logic [SW-1:0]         sum;
  logic [NUM_REQ-1:0]    ready;
  logic                  op_valid, rsp_valid;
  logic [TOTAL_BITS-1:0] op_a, op_b, prod, res, rsp_data;

  assign adv2 = op_valid & (~rsp_valid | bus.rsp_ready);
  assign adv1 = ~op_valid | adv2;

  // Scan from rr_ptr with wrap; reset_n gates the grant so nothing is offered during reset.
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + SW'(k);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      if (!gnt && bus.req_valid[sum[ID_BITS-1:0]]) begin
        gnt     = 1'b1;
        gnt_idx = sum[ID_BITS-1:0];
      end
    end
    gnt = gnt & adv1 & reset_n;
  end

  always_comb begin
    ready = '0;
    if (gnt) ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= '0;
      rr_ptr   <= '0;
    end else if (gnt) begin
      op_valid <= 1'b1;
      op_a     <= bus.req_a[int'(gnt_idx)*TOTAL_BITS +: TOTAL_BITS];
      op_b     <= bus.req_b[int'(gnt_idx)*TOTAL_BITS +: TOTAL_BITS];
      op_id    <= gnt_idx;
      rr_ptr   <= (gnt_idx == ID_BITS'(NUM_REQ-1)) ? '0 : gnt_idx + ID_BITS'(1);
    end else if (adv2) begin
      op_valid <= 1'b0;
    end
  end

  mul #(.TOTAL_BITS(TOTAL_BITS), .FRACTIONAL_BITS(FRACTIONAL_BITS)) u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

`ifdef MUL_ARB_SATURATE_EN
  logic [2*TOTAL_BITS-1:0] full;
  logic                    ovf, rsp_ovf;

  // Any product bit above the integer range of the result means overflow.
  assign full = {{TOTAL_BITS{1'b0}}, op_a} * {{TOTAL_BITS{1'b0}}, op_b};
  assign ovf  = |(full >> (TOTAL_BITS + FRACTIONAL_BITS));
  assign res  = ovf ? '1 : prod;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rsp_ovf <= 1'b0;
    else if (adv2) rsp_ovf <= ovf;
  end
  assign bus.rsp_ovf = rsp_ovf;
`else
  assign res         = prod;
  assign bus.rsp_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (adv2) begin
      rsp_valid <= 1'b1;
      rsp_data  <= res;
      rsp_id    <= op_id;
    end else if (bus.rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_id    = rsp_id;
  assign bus.busy      = op_valid | rsp_valid;
endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter at TOTAL_BITS=7, FRACTIONAL_BITS=3, NUM_REQ=4: vector table,
// round-robin, backpressure and mid-operation reset, with an in-order result scoreboard.
module tb_mul_arbiter;
  localparam int TB = 7, FB = 3, NR = 4, IB = 2;
`ifdef MUL_ARB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [TB-1:0] data;
    logic [IB-1:0] id;
    logic          ovf;
  } exp_t;

  typedef struct {
    int id;
    int a;
    int b;
    int exp_data;
    int exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   nvec = 0;
  int   nerr = 0;
  exp_t sb[$];

  mul_arbiter_if #(.TOTAL_BITS(TB), .NUM_REQ(NR), .ID_BITS(IB)) bus ();

  mul_arbiter #(.TOTAL_BITS(TB), .FRACTIONAL_BITS(FB), .NUM_REQ(NR), .ID_BITS(IB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int id, input int a, input int b);
    exp_t e;
    int   p;
    p      = a * b;
    e.id   = IB'(id);
    e.ovf  = (p >> (TB + FB)) != 0;
    e.data = TB'(p >> FB);
    if (SAT && e.ovf) e.data = '1;
    if (!SAT) e.ovf = 1'b0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops();
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*TB +: TB] = TB'(8 + i);
      bus.req_b[i*TB +: TB] = TB'(16);
    end
  endtask

  // Scoreboard: pushes on transfers, pops on consumer handshakes.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL sb_unexpected_rsp: got id %0d data 0x%0h with nothing outstanding", bus.rsp_id, bus.rsp_data);
        end else begin
          e = sb.pop_front();
          chk("sb_data", 32'(bus.rsp_data), 32'(e.data));
          chk("sb_id",   32'(bus.rsp_id),   32'(e.id));
          chk("sb_ovf",  32'(bus.rsp_ovf),  32'(e.ovf));
        end
      end
      for (int i = 0; i < NR; i++)
        if (bus.req_valid[i] && bus.req_ready[i])
          sb.push_back(model(i, int'(bus.req_a[i*TB +: TB]), int'(bus.req_b[i*TB +: TB])));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   xfers;

    vecs[0] = '{2, 'h0C, 'h10, 'h18, 0};
    vecs[1] = '{1, 'h78, 'h04, 'h3C, 0};
    vecs[2] = '{3, 'h78, 'h10, SAT ? 'h7F : 'h70, SAT ? 1 : 0};
    vecs[3] = '{0, 'h7F, 'h7F, SAT ? 'h7F : 'h60, SAT ? 1 : 0};
    vecs[4] = '{0, 'h08, 'h08, 'h08, 0};
    vecs[5] = '{2, 'h01, 'h01, 'h00, 0};
    vecs[6] = '{3, 'h07, 'h09, 'h07, 0};
    vecs[7] = '{1, 'h00, 'h55, 'h00, 0};

    // Reset state, with every requester asking.
    reset_n       = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    set_ops();
    repeat (2) step();
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_busy",      32'(bus.busy),      0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    0);
    chk("rst_rsp_ovf",   32'(bus.rsp_ovf),   0);
    bus.req_valid = '0;
    #1 reset_n = 1'b1;

    // Round-robin: grants 0,1,2,3,0,1; rsp_id trails by two cycles.
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) bus.req_valid = '1;
      if (k == 6) bus.req_valid = '0;
      @(negedge clk);
      chk("rr_grant", 32'(bus.req_ready), (k < 6) ? 32'(1 << (k % 4)) : 0);
      if (k >= 2) begin
        chk("rr_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("rr_rsp_id",    32'(bus.rsp_id),    32'((k - 2) % 4));
        chk("rr_rsp_data",  32'(bus.rsp_data),  32'(2 * (8 + (k - 2) % 4)));
      end
    end
    step();
    @(negedge clk);
    chk("rr_drained", 32'(sb.size()), 0);
    chk("rr_idle",    32'(bus.busy),  0);

    // Table of single-requester vectors with latency checks.
    foreach (vecs[v]) begin
      step();
      bus.req_valid = NR'(1 << vecs[v].id);
      bus.req_a[vecs[v].id*TB +: TB] = TB'(vecs[v].a);
      bus.req_b[vecs[v].id*TB +: TB] = TB'(vecs[v].b);
      @(negedge clk);
      chk("vec_grant", 32'(bus.req_ready), 32'(1 << vecs[v].id));
      step();
      bus.req_valid = '0;
      @(negedge clk);
      chk("vec_s1_only_valid", 32'(bus.rsp_valid), 0);
      chk("vec_s1_busy",       32'(bus.busy),      1);
      step();
      @(negedge clk);
      chk("vec_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("vec_rsp_data",  32'(bus.rsp_data),  32'(vecs[v].exp_data));
      chk("vec_rsp_id",    32'(bus.rsp_id),    32'(vecs[v].id));
      chk("vec_rsp_ovf",   32'(bus.rsp_ovf),   32'(vecs[v].exp_ovf));
      step();
      @(negedge clk);
      chk("vec_rsp_done", 32'(bus.rsp_valid), 0);
    end

    // Backpressure: last vector granted requester 1, so the scan resumes at 2.
    xfers = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 0) begin
        set_ops();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
      end
      @(negedge clk);
      xfers += $countones(bus.req_valid & bus.req_ready);
      if (c == 0) chk("bp_grant0", 32'(bus.req_ready), 32'h4);
      if (c == 1) chk("bp_grant1", 32'(bus.req_ready), 32'h8);
      if (c >= 2) begin
        chk("bp_no_grant",  32'(bus.req_ready), 0);
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("bp_rsp_id",    32'(bus.rsp_id),    2);
        chk("bp_rsp_data",  32'(bus.rsp_data),  32'h14);
      end
    end
    chk("bp_xfers", 32'(xfers), 2);
    step();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("bp_drained", 32'(sb.size()), 0);
    chk("bp_idle",    32'(bus.busy),  0);

    // Reset with both stages full.
    step();
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    repeat (2) step();
    chk("mr_full_rsp_valid", 32'(bus.rsp_valid), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("mr_req_ready", 32'(bus.req_ready), 0);
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mr_busy",      32'(bus.busy),      0);
    chk("mr_rsp_data",  32'(bus.rsp_data),  0);
    chk("mr_rsp_id",    32'(bus.rsp_id),    0);
    chk("mr_rsp_ovf",   32'(bus.rsp_ovf),   0);
    sb.delete();
    #1;
    reset_n       = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("mr_first_grant", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    repeat (3) step();
    @(negedge clk);
    chk("mr_drained", 32'(sb.size()),     0);
    chk("mr_idle",    32'(bus.rsp_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter that shares one unsigned fixed-point multiplier (`mul`) between `NUM_REQ` requesters, such as per-voice envelope and gain stages in the synth. Each requester presents an operand pair with a valid/ready handshake. Grants are issued round-robin. Results return through a two-stage registered pipeline, tagged with the requester ID and subject to downstream backpressure.

## Interface
- `TOTAL_BITS`, default 16: operand and result width in bits, unsigned fixed point.
- `FRACTIONAL_BITS`, default 12: number of fractional bits; passed to the internal `mul` instance.
- `NUM_REQ`, default 4: number of requesters, minimum 1.
- `ID_BITS`, default `$clog2(NUM_REQ)`, minimum 1: width of the requester tag.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  requester i has an operand pair.
- `req_ready`  out  NUM_REQ  one-hot or zero; bit i means requester i is granted this cycle.
- `req_a`, `req_b`  in  NUM_REQ*TOTAL_BITS  operands, flattened; requester i occupies bits [i*TOTAL_BITS +: TOTAL_BITS].
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  TOTAL_BITS  product.
- `rsp_id`  out  ID_BITS  index of the requester that issued the operands.
- `rsp_ovf`  out  1  saturation occurred (see Configuration).
- `busy`  out  1  `op_valid | rsp_valid`.

## Operation
- Stage S1 (operand register) holds `op_valid`, `op_a`, `op_b`, `op_id`.
- Stage S2 (output register) holds `rsp_valid`, `rsp_data`, `rsp_id`, `rsp_ovf`.
- `adv2 = op_valid & (~rsp_valid | rsp_ready)`.
- `adv1 = ~op_valid | adv2`.
- Arbitration, when `adv1` is high:
  - Scan `req_valid` starting at `rr_ptr` and wrapping, and raise `req_ready` for the first set bit only.
  - When `adv1` is low, `req_ready` is all zeros.
  - `req_ready` is combinational from `req_valid`, `rr_ptr`, and the pipeline state.
- A transfer is `req_valid[i] & req_ready[i]`. On a transfer:
  - S1 loads requester i's operands and `op_id = i`.
  - `rr_ptr` becomes i+1, wrapping from NUM_REQ-1 to 0.
  - Otherwise `rr_ptr` holds its value.
- S1 clears when `adv2` is high and there is no new transfer.
- S2 on `adv2`:
  - Loads `mul(op_a, op_b)`, plus `op_id` and the overflow flag.
  - When `rsp_valid & rsp_ready` and not `adv2`, `rsp_valid` clears.
  - Otherwise all S2 outputs hold stable.
- Arithmetic:
  - `rsp_data = ((a*b) >> FRACTIONAL_BITS) mod 2^TOTAL_BITS`.
  - The discarded fraction is truncated toward zero, matching `mul`.
  - The full 2*TOTAL_BITS product is formed internally for overflow detection.
  - Overflow means any product bit above TOTAL_BITS+FRACTIONAL_BITS-1 is set.
- Reset (`reset_n` low, asynchronous and effective at any time):
  - `op_valid`, `rsp_valid`, `rsp_ovf` go to 0.
  - `rsp_data`, `rsp_id`, `rr_ptr` go to 0.
  - `req_ready` goes to 0 and `busy` goes to 0.
  - Operations in flight are discarded and produce no response.
  - After release, arbitration starts at requester 0.
- NUM_REQ = 1: `rr_ptr` is constant 0 and `rsp_id` is constant 0.

## Timing
- Latency: a transfer in cycle n gives S1 valid in n+1 and `rsp_valid` in n+2, provided the output is not stalled.
- Throughput: one transfer per cycle while `rsp_ready` is held high.
- Stall:
  - While `rsp_valid & ~rsp_ready`, S2 holds.
  - S1 may fill once more, then `req_ready` is all zeros.
  - At most two results are buffered.
- Simultaneous events:
  - A consumer handshake and a new S2 load in the same cycle give back-to-back `rsp_valid`, with no bubble.
  - A transfer into S1 and an S1→S2 advance may occur in the same cycle.
- Fairness: a continuously asserted requester is granted within NUM_REQ transfers.

## Configuration
- Macro `MUL_ARB_SATURATE_EN` defined:
  - On overflow, `rsp_data` becomes all ones.
  - `rsp_ovf` is 1 for that result.
- Macro undefined:
  - The result wraps modulo 2^TOTAL_BITS, identical to `mul`.
  - `rsp_ovf` is tied to 0.
  - The overflow logic is not synthesised.

## Test plan
All scenarios use TOTAL_BITS=7, FRACTIONAL_BITS=3, NUM_REQ=4.
- **Basic:** requester 2 drives 0x0C (1.5) × 0x10 (2.0), `rsp_ready`=1. Expect `rsp_valid` two cycles after the transfer, `rsp_data`=0x18 (3.0), `rsp_id`=2, `rsp_ovf`=0.
- **Fraction:** 0x78 (15.0) × 0x04 (0.5) gives 0x3C (7.5).
- **Wrap vs. saturate:** 0x78 × 0x10. Without the macro, expect 0x70 with `rsp_ovf`=0. With `MUL_ARB_SATURATE_EN`, expect 0x7F with `rsp_ovf`=1.
- **Round-robin:** all four `req_valid` held high with `rsp_ready`=1. Grants run 0,1,2,3,0,1, one per cycle, and `rsp_id` follows the same sequence two cycles later.
- **Backpressure:** `rsp_ready`=0 for 4 cycles with all requesters active.
  - Exactly two transfers are accepted, then `req_ready`=0.
  - `rsp_data` and `rsp_id` stay constant during the stall.
  - After release, both results drain in order with no loss or duplication.
- **Reset mid-operation:** pulse `reset_n` low while S1 and S2 are both full. All outputs go to 0 immediately, no stale response appears afterward, and the first grant after reset goes to requester 0.
